// File: rtl/ysyx_23060061_lsu.sv
// Load/store unit: one outstanding aligned word access per request, byte-strobed stores,
// sign/zero-extended loads, with an error path for illegal, misaligned or timed-out ops.
module ysyx_23060061_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_memrw,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; the memory
    // response is a one-cycle pulse with no backpressure and is only sampled in WAIT.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_rdata_q, out_rdata_d;
    logic        out_err_q, out_err_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  ld_off_q, ld_off_d;

    logic        is_load, is_store, f3_ok, misal;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        is_load  = (in_memrw == 2'b10);
        is_store = (in_memrw == 2'b01);
        f3_ok    = 1'b0;
        if (is_load) begin
            case (in_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
                default:                                f3_ok = 1'b0;
            endcase
        end else if (is_store) begin
            case (in_funct3)
                3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
                default:                f3_ok = 1'b0;
            endcase
        end
        misal = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
        case (in_funct3[1:0])
            2'b00: begin
                st_wdata = {4{in_wdata[7:0]}};
                st_wstrb = 4'b0001 << in_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{in_wdata[15:0]}};
                st_wstrb = 4'b0011 << in_addr[1:0];
            end
            default: begin
                st_wdata = in_wdata;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[{ld_off_q, 3'b000} +: 8];
        ld_half = ld_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ld_f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_rdata_d = out_rdata_q;
        out_err_d   = out_err_q;
        req_valid_d = req_valid_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        ld_f3_d     = ld_f3_q;
        ld_off_d    = ld_off_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_memrw == 2'b00) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b0;
                        out_rdata_d = 32'd0;
                    end else if (!f3_ok || misal) begin
                        // Covers memrw==11 too: neither load nor store, so f3_ok stays 0.
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                        out_rdata_d = 32'd0;
                    end else begin
                        state_d     = S_REQ;
                        req_valid_d = 1'b1;
                        addr_d      = {in_addr[31:2], 2'b00};
                        wen_d       = is_store;
                        wdata_d     = is_store ? st_wdata : 32'd0;
                        wstrb_d     = is_store ? st_wstrb : 4'b0000;
                        ld_f3_d     = in_funct3;
                        ld_off_d    = in_addr[1:0];
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d     = S_WAIT;
                    req_valid_d = 1'b0;
                    cnt_d       = 8'd0;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b0;
                    out_rdata_d = wen_q ? 32'd0 : ld_data;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b1;
                    out_rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            out_valid_q <= 1'b0;
            out_rdata_q <= 32'd0;
            out_err_q   <= 1'b0;
            req_valid_q <= 1'b0;
            addr_q      <= 32'd0;
            wen_q       <= 1'b0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            ld_f3_q     <= 3'd0;
            ld_off_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_rdata_q <= out_rdata_d;
            out_err_q   <= out_err_d;
            req_valid_q <= req_valid_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            ld_f3_q     <= ld_f3_d;
            ld_off_q    <= ld_off_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE) && !rst;
    assign out_valid     = out_valid_q;
    assign out_rdata     = out_rdata_q;
    assign out_err       = out_err_q;
    assign mem_req_valid = req_valid_q;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_ysyx_23060061_lsu.sv
// Directed bench for the load/store unit: hand-computed vectors for loads, stores,
// error paths, stalls, timeout and reset.
module tb_ysyx_23060061_lsu;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_memrw;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [32:0] exp_q[$];

    ysyx_23060061_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_memrw(in_memrw),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic issue(input logic [1:0] rw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        check("in_ready_pre", in_ready, 1);
        in_valid  = 1'b1;
        in_memrw  = rw;
        in_funct3 = f3;
        in_addr   = addr;
        in_wdata  = wd;
        step();
        in_valid  = 1'b0;
        in_memrw  = 2'b00;
        in_funct3 = 3'b000;
        in_addr   = 32'd0;
        in_wdata  = 32'd0;
    endtask

    task automatic collect(input string tag);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_result"}, {out_err, out_rdata}, e);
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_vld_clr"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic run_mem(input string tag, input logic [1:0] rw, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rsp, input logic [31:0] exp_addr,
                           input logic exp_wen, input logic [31:0] exp_wdata,
                           input logic [3:0] exp_wstrb, input logic [31:0] exp_rdata);
        exp_q.push_back({1'b0, exp_rdata});
        issue(rw, f3, addr, wd);
        check({tag, "_req_valid"}, mem_req_valid, 1);
        check({tag, "_addr"}, mem_addr, exp_addr);
        check({tag, "_wen"}, mem_wen, exp_wen);
        check({tag, "_wdata"}, mem_wdata, exp_wdata);
        check({tag, "_wstrb"}, mem_wstrb, exp_wstrb);
        check({tag, "_early_vld1"}, out_valid, 0);
        step();
        check({tag, "_wait"}, dbg_state, 2'd2);
        check({tag, "_early_vld2"}, out_valid, 0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = rsp;
        step();
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'd0;
        check({tag, "_out_valid"}, out_valid, 1);
        collect(tag);
        handshake(tag);
    endtask

    task automatic run_nomem(input string tag, input logic [1:0] rw, input logic [2:0] f3,
                             input logic [31:0] addr, input logic exp_err);
        exp_q.push_back({exp_err, 32'd0});
        issue(rw, f3, addr, 32'hFFFF_FFFF);
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_no_req"}, mem_req_valid, 0);
        collect(tag);
        handshake(tag);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_memrw = 2'b00; in_funct3 = 3'b000;
        in_addr = 32'd0; in_wdata = 32'd0; out_ready = 1'b0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rdata = 32'd0;
        step();
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_rdata", out_rdata, 0);
        check("rst_out_err", out_err, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        #1;
        check("rst_rel_in_ready", in_ready, 1);

        // loads and stores through memory
        run_mem("lw",  2'b10, 3'b010, 32'h8000_0004, 32'd0, 32'hDEAD_BEEF,
                32'h8000_0004, 1'b0, 32'd0, 4'b0000, 32'hDEAD_BEEF);
        run_mem("lb",  2'b10, 3'b000, 32'h8000_0003, 32'd0, 32'h80FF_7F01,
                32'h8000_0000, 1'b0, 32'd0, 4'b0000, 32'hFFFF_FF80);
        run_mem("lbu", 2'b10, 3'b100, 32'h8000_0003, 32'd0, 32'h80FF_7F01,
                32'h8000_0000, 1'b0, 32'd0, 4'b0000, 32'h0000_0080);
        run_mem("lh",  2'b10, 3'b001, 32'h8000_0002, 32'd0, 32'h80FF_7F01,
                32'h8000_0000, 1'b0, 32'd0, 4'b0000, 32'hFFFF_80FF);
        run_mem("lhu", 2'b10, 3'b101, 32'h8000_0002, 32'd0, 32'h80FF_7F01,
                32'h8000_0000, 1'b0, 32'd0, 4'b0000, 32'h0000_80FF);
        run_mem("lb1", 2'b10, 3'b000, 32'h8000_0001, 32'd0, 32'h80FF_7F01,
                32'h8000_0000, 1'b0, 32'd0, 4'b0000, 32'h0000_007F);
        run_mem("sb",  2'b01, 3'b000, 32'h1000_0001, 32'h1234_56AB, 32'h5555_5555,
                32'h1000_0000, 1'b1, 32'hABAB_ABAB, 4'b0010, 32'd0);
        run_mem("sh",  2'b01, 3'b001, 32'h1000_0002, 32'hFFFF_1234, 32'h5555_5555,
                32'h1000_0000, 1'b1, 32'h1234_1234, 4'b1100, 32'd0);
        run_mem("sw",  2'b01, 3'b010, 32'h1000_0008, 32'hCAFE_F00D, 32'h5555_5555,
                32'h1000_0008, 1'b1, 32'hCAFE_F00D, 4'b1111, 32'd0);

        // paths that never touch memory
        run_nomem("sw_misal",  2'b01, 3'b010, 32'h1000_0002, 1'b1);
        run_nomem("lh_misal",  2'b10, 3'b001, 32'h1000_0001, 1'b1);
        run_nomem("idle_code", 2'b00, 3'b010, 32'h1000_0000, 1'b0);
        run_nomem("illegal",   2'b11, 3'b010, 32'h1000_0000, 1'b1);
        run_nomem("ld_f3_011", 2'b10, 3'b011, 32'h1000_0000, 1'b1);
        run_nomem("st_f3_100", 2'b01, 3'b100, 32'h1000_0000, 1'b1);

        // request stall then output backpressure
        mem_req_ready = 1'b0;
        exp_q.push_back({1'b0, 32'h0000_7FFF});
        issue(2'b10, 3'b101, 32'h2000_0002, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("stall_req_valid", mem_req_valid, 1);
            check("stall_addr", mem_addr, 32'h2000_0000);
            check("stall_wstrb", mem_wstrb, 4'b0000);
            check("stall_in_ready", in_ready, 0);
            step();
        end
        mem_req_ready = 1'b1;
        step();
        check("stall_wait", dbg_state, 2'd2);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h7FFF_0000;
        step();
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'd0;
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", out_valid, 1);
            check("hold_rdata", out_rdata, 32'h0000_7FFF);
            check("hold_in_ready", in_ready, 0);
            step();
        end
        collect("stall");
        handshake("stall");

        // timeout with no response, then a late response
        exp_q.push_back({1'b1, 32'd0});
        issue(2'b10, 3'b010, 32'h3000_0000, 32'd0);
        step();
        check("to_wait", dbg_state, 2'd2);
        for (int i = 0; i < 4; i++) begin
            step();
            check("to_not_yet", out_valid, 0);
        end
        step();
        check("to_valid", out_valid, 1);
        collect("timeout");
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hFFFF_FFFF;
        step();
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'd0;
        check("late_rdata", out_rdata, 0);
        check("late_err", out_err, 1);
        check("late_valid", out_valid, 1);
        handshake("timeout");
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        check("idle_rsp_ignored", out_valid, 0);
        check("idle_state", dbg_state, 2'd0);

        // reset while waiting on memory
        issue(2'b01, 3'b010, 32'h4000_0004, 32'h55AA_55AA);
        step();
        check("rw_wait", dbg_state, 2'd2);
        check("rw_wen_set", mem_wen, 1);
        rst = 1'b1;
        #1;
        check("rw_in_ready_rst", in_ready, 0);
        step();
        rst = 1'b0;
        check("rw_state", dbg_state, 2'd0);
        check("rw_out_valid", out_valid, 0);
        check("rw_out_rdata", out_rdata, 0);
        check("rw_out_err", out_err, 0);
        check("rw_req_valid", mem_req_valid, 0);
        check("rw_addr", mem_addr, 0);
        check("rw_wen", mem_wen, 0);
        check("rw_wdata", mem_wdata, 0);
        check("rw_wstrb", mem_wstrb, 0);
        #1;
        check("rw_in_ready", in_ready, 1);

        // report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ysyx_23060061_lsu.md
# ysyx_23060061_lsu

Load/store unit between the execute stage and the data-memory port. It accepts one memory operation per transaction, tagged with the decoder's 2-bit `MemRW` code and `funct3`. It issues an aligned, byte-strobed word access over a valid/ready request / valid-only response memory port, and returns sign- or zero-extended load data to write-back. It is a single-outstanding, non-pipelined responder to the decoder's memory-control outputs.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in WAIT before aborting with error; 8-bit counter, range 1..255.

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: upstream request valid.
- `in_ready` out 1: unit can accept; `state==IDLE && !rst`.
- `in_memrw` in 2: 00 idle, 10 read, 01 write, 11 illegal.
- `in_funct3` in 3: access width/sign (RV32I load/store encoding).
- `in_addr` in 32: byte address.
- `in_wdata` in 32: store data, right-aligned.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts result.
- `out_rdata` out 32: extended load data; 0 for stores, idle and errors.
- `out_err` out 1: misaligned, illegal code/funct3, or timeout.
- `mem_req_valid` out 1: memory request valid.
- `mem_req_ready` in 1: memory accepts request.
- `mem_addr` out 32: `{in_addr[31:2], 2'b00}`.
- `mem_wen` out 1: 1 for a store.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wstrb` out 4: byte strobes; 0000 for loads.
- `mem_rsp_valid` in 1: response valid; single-cycle pulse, no backpressure.
- `mem_rdata` in 32: read word; ignored for stores.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset value is IDLE.
- Reset values of all registered outputs are 0: `out_valid`, `out_rdata`, `out_err`, `mem_req_valid`, `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wstrb`. The timeout counter resets to 0.
- IDLE: on `in_valid && in_ready`, register the request, then classify it:
  - `memrw==00`: go to DONE, err=0, rdata=0.
  - `memrw==11`: go to DONE, err=1.
  - Funct3 not in the legal set: go to DONE, err=1. Loads allow 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores allow 000 sb, 001 sh, 010 sw.
  - Misaligned access: go to DONE, err=1, with no memory access. Half is misaligned when `addr[0]=1`; word when `addr[1:0]!=0`.
  - Otherwise: go to REQ.
- REQ: `mem_req_valid=1`. Address, wen, wdata and wstrb are held stable until `mem_req_ready`; then go to WAIT and clear the counter.
- WAIT: the counter increments each cycle.
  - On `mem_rsp_valid`: capture the formatted result, err=0, go to DONE.
  - If the counter reaches TIMEOUT first: go to DONE, err=1, rdata=0.
  - A response in the same cycle the counter hits TIMEOUT wins and completes normally.
- DONE: `out_valid=1` with stable data and err until `out_ready`; then go to IDLE.
- `mem_rsp_valid` outside WAIT is ignored. This includes a late response after a timeout.
- Store formatting, with `o=addr[1:0]`:
  - sb: strobe `0001<<o`, wdata = byte replicated ×4.
  - sh: strobe `0011<<o`, wdata = half replicated ×2.
  - sw: strobe 1111, wdata unchanged.
- Load formatting: select byte `o` or half `addr[1]`; lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
- `rst` asserted in any state returns to IDLE next edge and clears all outputs. An in-flight memory request is abandoned.

## Timing
- Request accepted at edge T.
- Non-memory paths (idle code, errors): `out_valid` from T+1.
- Memory path with ready memory: `mem_req_valid` at T+1. With `mem_req_ready=1`, WAIT at T+2. A response at T+2 gives `out_valid` at T+3, so minimum latency is 3 cycles.
- A response in the same cycle as the request handshake is not legal for memory; the unit does not sample it.
- `in_ready` is low from T+1 until the cycle after the `out_valid && out_ready` handshake. Throughput is at most one operation per 4 cycles.
- Timeout: err asserts TIMEOUT+1 cycles after entering WAIT.

## Test plan
- lw from 0x80000004, memory returns 0xDEADBEEF at the earliest cycle -> `mem_addr`=0x80000004, `mem_wstrb`=0000, `out_rdata`=0xDEADBEEF, err=0, `out_valid` exactly 3 cycles after accept.
- lb/lbu from 0x80000003 with `mem_rdata`=0x80FF7F01 -> lb gives 0xFFFFFF80, lbu gives 0x00000080. lh from 0x80000002 gives 0xFFFF80FF.
- sb 0xAB to 0x10000001 -> `mem_wstrb`=0010, `mem_wdata`=0xABABABAB, `mem_wen`=1. sh 0x1234 to 0x10000002 -> strobe 1100, wdata 0x12341234.
- sw to 0x10000002 and lh from 0x10000001 -> err=1 at T+1, `mem_req_valid` never asserts. `memrw`=00 -> err=0, rdata=0 at T+1.
- `mem_req_ready` low for 5 cycles with `out_ready` low for 3 cycles -> request fields stay stable throughout, result is held, and `in_ready` stays 0 until the output handshake.
- TIMEOUT=4 and no response -> err=1, rdata=0 five cycles after entering WAIT; a late `mem_rsp_valid` is ignored. Asserting `rst` in WAIT -> IDLE and all outputs 0 on the next edge.
